multicycle_ctrl_fsm: RTL

//  Multicycle main controller directly upstream of the condition/flag logic stage.

---
 rtl/multicycle_ctrl_fsm.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle main controller: sequences each instruction from FETCH through
// writeback and emits raw datapath selects plus CondEx-gated write enables.
//
// state  | meaning
// -------+-------------------------------------------------
// FETCH  | load IR, PC <= PC + 4
// DECODE | read registers, precompute PC + 8
// MEMADR | compute memory address (base + imm)
// MEMRD  | read data memory at ALUOut
// MEMWB  | write loaded data to register file
// MEMWR  | write data memory at ALUOut
// EXECR  | ALU op with register operand B
// EXECI  | ALU op with immediate operand B
// ALUWB  | write ALU result and flags
// BRANCH | PC <= branch target when condition passes
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               CondEx,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUControl,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic [1:0]         FlagWrite,
  output logic               SatWrite,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t state_q;

  logic       next_pc, branch, reg_w, mem_w, alu_op;
  logic       no_write, sat_op, write_ok;
  logic [1:0] flag_w, alu_ctl;

  assign State = STATE_W'(state_q);

  // State register: one transition per clock, reset and illegal codes return to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          case (Op)
            2'b00:   state_q <= Funct[5] ? S_EXECI : S_EXECR;
            2'b01:   state_q <= S_MEMADR;
            2'b10:   state_q <= S_BRANCH;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: state_q <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_q <= S_MEMWB;
        S_EXECR:  state_q <= S_ALUWB;
        S_EXECI:  state_q <= S_ALUWB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore selects per state, ALU decode, then CondEx gating of all write enables.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next_pc   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_EXECR:  alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB: begin
        reg_w  = 1'b1;
        alu_op = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase

    alu_ctl  = 2'b00;
    no_write = 1'b0;
    flag_w   = 2'b00;
    sat_op   = 1'b0;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin
          alu_ctl = 2'b00;
          flag_w  = {2{Funct[0]}};
          sat_op  = Funct[0];
        end
        4'b0010: begin
          alu_ctl = 2'b01;
          flag_w  = {2{Funct[0]}};
          sat_op  = Funct[0];
        end
        4'b0000: begin
          alu_ctl = 2'b10;
          flag_w  = {Funct[0], 1'b0};
        end
        4'b1100: begin
          alu_ctl = 2'b11;
          flag_w  = {Funct[0], 1'b0};
        end
        4'b1010: begin
          alu_ctl  = 2'b01;
          no_write = 1'b1;
          flag_w   = 2'b11;
        end
        default: no_write = 1'b1;
      endcase
    end

    // A reset edge must never commit a partial write from an aborted instruction.
    write_ok   = CondEx & ~reset;
    ALUControl = alu_ctl;
    PCWrite    = next_pc | (branch & write_ok);
    RegWrite   = reg_w & ~no_write & write_ok;
    MemWrite   = mem_w & write_ok;
    FlagWrite  = (state_q == S_ALUWB) ? (flag_w & {2{write_ok}}) : 2'b00;
    SatWrite   = (state_q == S_ALUWB) & sat_op & write_ok;
  end

endmodule
